// File: rtl/ram_burst_reader_pkg.sv
// ============================================================================
// Module      : ram_rd_pkg
// Description : Shared types and default widths for the RAM burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_rd_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned STATE_W        = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_t;

endpackage : ram_rd_pkg

`default_nettype wire

// File: rtl/ram_burst_reader_stream_out_reg.sv
// ============================================================================
// Module      : stream_out_reg
// Description : Single-entry valid/data/last output register with load/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_out_reg
  import ram_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  load_last_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  last_q,  last_d;

  // A load in the same cycle as a pop replaces the consumed word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      last_d  = load_last_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule : stream_out_reg

`default_nettype wire

// File: rtl/ram_burst_reader.sv
// ============================================================================
// Module      : ram_burst_reader
// Description : Drains a contiguous RAM burst into a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [LEN_WIDTH-1:0]  rem_q,   rem_d;

  logic fire;
  logic last_beat;
  logic pop;
  logic out_valid;

  // Issue a read only when the output slot is free or being emptied this cycle.
  assign fire      = (state_q == READ) && (!out_valid || m_ready) && (rem_q != '0);
  assign last_beat = (rem_q == LEN_WIDTH'(1));
  assign pop       = out_valid && m_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (fire && last_beat) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    rd_en = 1'b0;
    case (state_q)
      READ: begin
        busy  = 1'b1;
        rd_en = fire;
      end
      DRAIN:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------ address / length counters
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if ((state_q == IDLE) && start && (length != '0)) begin
      addr_d = base_addr;
      rem_d  = length;
    end else if (fire) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign read_addr = addr_q;

  // ------------------------------------------------------------ output stage
  stream_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .clk_i       (wr_clk),
    .rst_i       (reset),
    .load_i      (fire),
    .load_data_i (read_data),
    .load_last_i (last_beat),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .data_o      (m_data),
    .last_o      (m_last)
  );

  assign m_valid = out_valid;

endmodule : ram_burst_reader

`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
// ============================================================================
// Module      : tb_ram_burst_reader
// Description : Directed self-checking bench for ram_burst_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_burst_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = AW + 1;

  logic          wr_clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic [DW-1:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  assign read_data = mem[read_addr];

  ram_burst_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .wr_clk    (wr_clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .read_addr (read_addr),
    .read_data (read_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    @(negedge wr_clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy,      1'b0);
    check({tag, "_done"},  done,      1'b0);
    check({tag, "_rden"},  rd_en,     1'b0);
    check({tag, "_addr"},  read_addr, 8'd0);
    check({tag, "_valid"}, m_valid,   1'b0);
    check({tag, "_data"},  m_data,    32'd0);
    check({tag, "_last"},  m_last,    1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit      done_seen;
    int      idx;
    bit      ready_pat [4];

    for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | i;
    mem[10] = 32'hA0; mem[11] = 32'hA1; mem[12] = 32'hA2; mem[13] = 32'hA3;
    mem[255] = 32'hB0FF; mem[0] = 32'hB000; mem[1] = 32'hB001;
    mem[20] = 32'hC0; mem[21] = 32'hC1; mem[22] = 32'hC2; mem[23] = 32'hC3; mem[24] = 32'hC4;

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    tick(); tick();
    #1 check_idle_outputs("rst");
    reset = 1'b0;
    tick();

    // Burst 1: base 10, len 4, consumer always ready.
    m_ready = 1'b1; base_addr = 8'd10; length = 9'd4; start = 1'b1;
    #1 check("t1_busy_T", busy, 1'b0);
    tick(); start = 1'b0;
    #1;
    check("t1_busy_T1",  busy,      1'b1);
    check("t1_rden_T1",  rd_en,     1'b1);
    check("t1_addr_T1",  read_addr, 8'd10);
    check("t1_valid_T1", m_valid,   1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("t1_valid", m_valid, 1'b1);
      check("t1_data",  m_data,  32'hA0 + k);
      check("t1_last",  m_last,  k == 3);
      check("t1_done",  done,    1'b0);
    end
    check("t1_rden_drain", rd_en, 1'b0);
    tick(); #1;
    check("t1_done_T6",  done,    1'b1);
    check("t1_busy_T6",  busy,    1'b0);
    check("t1_valid_T6", m_valid, 1'b0);
    check("t1_last_T6",  m_last,  1'b0);
    tick(); #1;
    check("t1_done_T7",  done,    1'b0);

    // Burst 2: same burst under backpressure pattern 1,0,0,1.
    ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0; ready_pat[3] = 1'b1;
    m_ready = 1'b1; base_addr = 8'd10; length = 9'd4; start = 1'b1;
    tick(); start = 1'b0;
    idx = 0; done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      m_ready = ready_pat[c % 4];
      #1;
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      if (m_valid) begin
        check("t2_data", m_data, 32'hA0 + idx);
        check("t2_last", m_last, idx == 3);
        if (m_ready) idx++;
        else check("t2_stall_rden", rd_en, 1'b0);
      end
      tick();
    end
    check("t2_done_seen", done_seen, 1'b1);
    check("t2_words",     idx,       4);
    m_ready = 1'b1;
    tick();

    // Burst 3: address wrap 255 -> 0 -> 1.
    base_addr = 8'd255; length = 9'd3; start = 1'b1;
    tick(); start = 1'b0;
    #1 check("t3_addr_T1", read_addr, 8'd255);
    tick(); #1;
    check("t3_addr_T2", read_addr, 8'd0);
    check("t3_data0",   m_data,    32'hB0FF);
    tick(); #1;
    check("t3_addr_T3", read_addr, 8'd1);
    check("t3_data1",   m_data,    32'hB000);
    check("t3_last1",   m_last,    1'b0);
    tick(); #1;
    check("t3_data2",   m_data,    32'hB001);
    check("t3_last2",   m_last,    1'b1);
    tick(); #1;
    check("t3_done",    done,      1'b1);
    tick();

    // Burst 4: zero length.
    base_addr = 8'd40; length = 9'd0; start = 1'b1;
    tick(); start = 1'b0;
    #1;
    check("t4_done_T1",  done,    1'b1);
    check("t4_busy_T1",  busy,    1'b0);
    check("t4_valid_T1", m_valid, 1'b0);
    check("t4_rden_T1",  rd_en,   1'b0);
    check("t4_last_T1",  m_last,  1'b0);
    tick(); #1;
    check("t4_done_T2",  done,    1'b0);
    check("t4_busy_T2",  busy,    1'b0);
    check("t4_valid_T2", m_valid, 1'b0);

    // Burst 5: restart attempt mid-burst is ignored.
    base_addr = 8'd10; length = 9'd4; start = 1'b1;
    tick(); start = 1'b1; base_addr = 8'd200; length = 9'd2;
    #1 check("t5_addr_T1", read_addr, 8'd10);
    tick(); start = 1'b0;
    #1 check("t5_addr_T2", read_addr, 8'd11);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin tick(); #1; end
      check("t5_data", m_data, 32'hA0 + k);
      check("t5_last", m_last, k == 3);
    end
    tick(); #1;
    check("t5_done", done, 1'b1);
    tick();

    // Burst 6: reset on word 2 of a 5-word burst, then a fresh burst.
    base_addr = 8'd20; length = 9'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick(); #1 check("t6_data0", m_data, 32'hC0);
    tick(); #1 check("t6_data1", m_data, 32'hC1);
    tick(); #1 check("t6_data2", m_data, 32'hC2);
    #2 reset = 1'b1;
    #1 check_idle_outputs("t6_async");
    tick(); #1 check("t6_done_rst", done, 1'b0);
    reset = 1'b0;
    tick(); #1 check("t6_done_after", done, 1'b0);
    base_addr = 8'd20; length = 9'd2; start = 1'b1;
    tick(); start = 1'b0;
    tick(); #1;
    check("t6_new_data0", m_data, 32'hC0);
    check("t6_new_last0", m_last, 1'b0);
    tick(); #1;
    check("t6_new_data1", m_data, 32'hC1);
    check("t6_new_last1", m_last, 1'b1);
    tick(); #1;
    check("t6_new_done", done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_ram_burst_reader

`default_nettype wire
